// File: rtl/alu_rs_bank_if.sv
// Issue, CDB snoop and ALU dispatch bundle for the ALU reservation-station bank.
// master = issue/CDB/ALU side, slave = the station bank.
interface alu_rs_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int OP_WIDTH   = 4
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [OP_WIDTH-1:0]   issue_op;
    logic [DATA_WIDTH-1:0] issue_Vj;
    logic [DATA_WIDTH-1:0] issue_Vk;
    logic [TAG_WIDTH-1:0]  issue_Qj;
    logic [TAG_WIDTH-1:0]  issue_Qk;
    logic                  issue_rj;
    logic                  issue_rk;
    logic [TAG_WIDTH-1:0]  issue_dest;
    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [TAG_WIDTH-1:0]  alu_dest;

    modport master (
        output issue_valid, issue_op, issue_Vj, issue_Vk, issue_Qj, issue_Qk,
               issue_rj, issue_rk, issue_dest, cdb_valid, cdb_tag, cdb_data, alu_ready,
        input  issue_ready, alu_valid, alu_op, alu_a, alu_b, alu_dest
    );
    modport slave (
        input  issue_valid, issue_op, issue_Vj, issue_Vk, issue_Qj, issue_Qk,
               issue_rj, issue_rk, issue_dest, cdb_valid, cdb_tag, cdb_data, alu_ready,
        output issue_ready, alu_valid, alu_op, alu_a, alu_b, alu_dest
    );
endinterface

// File: rtl/alu_rs_bank.sv
// ALU reservation-station bank: free-slot allocation, CDB wakeup, one registered dispatch per cycle.
// Optional RS_AGE_SELECT_EN: oldest-ready selection via per-entry age ranks (default lowest index).
module alu_rs_bank #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int TAG_WIDTH   = 3,
    parameter  int NUM_ENTRIES = 4,
    parameter  int OP_WIDTH    = 4,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    alu_rs_bank_if.slave           rs_if,
    output logic [NUM_ENTRIES-1:0] busy_out,
    output logic [CNT_W-1:0]       busy_count
);
    logic [NUM_ENTRIES-1:0]                 busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [NUM_ENTRIES-1:0][TAG_WIDTH-1:0]  qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
    logic [NUM_ENTRIES-1:0][OP_WIDTH-1:0]   op_q, op_d;
    logic                  alu_valid_q, alu_valid_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [TAG_WIDTH-1:0]  alu_dest_q, alu_dest_d;

    logic [NUM_ENTRIES-1:0] sel_vec;
    logic [IDX_W-1:0]       free_idx, sel_idx;
    logic                   issue_fire, load_out, byp_j, byp_k;

    assign rs_if.issue_ready = ~&busy_q;
    assign issue_fire = rs_if.issue_valid & rs_if.issue_ready;
    assign sel_vec    = busy_q & rj_q & rk_q;
    assign load_out   = (~alu_valid_q | rs_if.alu_ready) & |sel_vec;
    assign byp_j = rs_if.cdb_valid & ~rs_if.issue_rj & (rs_if.issue_Qj == rs_if.cdb_tag);
    assign byp_k = rs_if.cdb_valid & ~rs_if.issue_rk & (rs_if.issue_Qk == rs_if.cdb_tag);

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!busy_q[i]) free_idx = IDX_W'(i);
    end

`ifdef RS_AGE_SELECT_EN
    // rank = number of younger busy entries, so ranks stay unique among busy entries
    logic [NUM_ENTRIES-1:0][IDX_W-1:0] rank_q, rank_d;
    logic found;

    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (sel_vec[i] && (!found || rank_q[i] > rank_q[sel_idx])) begin
                sel_idx = IDX_W'(i);
                found   = 1'b1;
            end
    end

    always_comb begin
        logic inc, dec;
        rank_d = rank_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            inc = issue_fire && !(load_out && sel_idx == IDX_W'(i));
            dec = load_out && rank_q[i] > rank_q[sel_idx];
            if (issue_fire && !busy_q[i] && free_idx == IDX_W'(i))
                rank_d[i] = '0;
            else if (busy_q[i] && inc && !dec && rank_q[i] != IDX_W'(NUM_ENTRIES - 1))
                rank_d[i] = rank_q[i] + 1'b1;
            else if (busy_q[i] && !inc && dec)
                rank_d[i] = rank_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) rank_q <= '0;
        else                rank_q <= rank_d;
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (sel_vec[i]) sel_idx = IDX_W'(i);
    end
`endif

    always_comb begin
        busy_d = busy_q; rj_d = rj_q; rk_d = rk_q; vj_d = vj_q; vk_d = vk_q;
        qj_d = qj_q; qk_d = qk_q; dest_d = dest_q; op_d = op_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (busy_q[i] && !rj_q[i] && rs_if.cdb_valid && qj_q[i] == rs_if.cdb_tag) begin
                vj_d[i] = rs_if.cdb_data;
                rj_d[i] = 1'b1;
            end
            if (busy_q[i] && !rk_q[i] && rs_if.cdb_valid && qk_q[i] == rs_if.cdb_tag) begin
                vk_d[i] = rs_if.cdb_data;
                rk_d[i] = 1'b1;
            end
            if (load_out && sel_idx == IDX_W'(i))
                busy_d[i] = 1'b0;
            // free_idx only ever names a non-busy slot, so issue never collides with the above
            if (issue_fire && free_idx == IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                op_d[i]   = rs_if.issue_op;
                dest_d[i] = rs_if.issue_dest;
                qj_d[i]   = rs_if.issue_Qj;
                qk_d[i]   = rs_if.issue_Qk;
                rj_d[i]   = rs_if.issue_rj | byp_j;
                rk_d[i]   = rs_if.issue_rk | byp_k;
                vj_d[i]   = byp_j ? rs_if.cdb_data : rs_if.issue_Vj;
                vk_d[i]   = byp_k ? rs_if.cdb_data : rs_if.issue_Vk;
            end
        end
    end

    always_comb begin
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_dest_d  = alu_dest_q;
        if (load_out) begin
            alu_valid_d = 1'b1;
            alu_op_d    = op_q[sel_idx];
            alu_a_d     = vj_q[sel_idx];
            alu_b_d     = vk_q[sel_idx];
            alu_dest_d  = dest_q[sel_idx];
        end else if (rs_if.alu_ready) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            busy_q <= '0; rj_q <= '0; rk_q <= '0; vj_q <= '0; vk_q <= '0;
            qj_q <= '0; qk_q <= '0; dest_q <= '0; op_q <= '0;
            alu_valid_q <= 1'b0; alu_op_q <= '0; alu_a_q <= '0; alu_b_q <= '0; alu_dest_q <= '0;
        end else begin
            busy_q <= busy_d; rj_q <= rj_d; rk_q <= rk_d; vj_q <= vj_d; vk_q <= vk_d;
            qj_q <= qj_d; qk_q <= qk_d; dest_q <= dest_d; op_q <= op_d;
            alu_valid_q <= alu_valid_d; alu_op_q <= alu_op_d; alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d; alu_dest_q <= alu_dest_d;
        end
    end

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            busy_count = busy_count + CNT_W'(busy_q[i]);
    end

    assign busy_out       = busy_q;
    assign rs_if.alu_valid = alu_valid_q;
    assign rs_if.alu_op    = alu_op_q;
    assign rs_if.alu_a     = alu_a_q;
    assign rs_if.alu_b     = alu_b_q;
    assign rs_if.alu_dest  = alu_dest_q;
endmodule

// File: tb/tb_alu_rs_bank.sv
// Directed bench for alu_rs_bank: latency, wakeup/bypass, full, flush, selection order, throughput.
module tb_alu_rs_bank;
    logic       clk, reset, flush;
    logic [3:0] busy_out;
    logic [2:0] busy_count;
    int checks = 0;
    int errors = 0;
    logic [2:0] exp3 [4];
    logic [2:0] exp5 [2];

    alu_rs_bank_if #(.DATA_WIDTH(16), .TAG_WIDTH(3), .OP_WIDTH(4)) bus ();

    alu_rs_bank #(.DATA_WIDTH(16), .TAG_WIDTH(3), .NUM_ENTRIES(4), .OP_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .rs_if(bus.slave),
        .busy_out(busy_out), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("check %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic iss(input logic [15:0] vj, input logic [15:0] vk, input logic [2:0] qj,
                       input logic rj, input logic [2:0] dest);
        bus.issue_valid = 1'b1;
        bus.issue_op    = 4'h1;
        bus.issue_Vj    = vj;
        bus.issue_Vk    = vk;
        bus.issue_Qj    = qj;
        bus.issue_Qk    = 3'd0;
        bus.issue_rj    = rj;
        bus.issue_rk    = 1'b1;
        bus.issue_dest  = dest;
    endtask

    task automatic cdb(input logic v, input logic [2:0] tag, input logic [15:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    initial begin
`ifdef RS_AGE_SELECT_EN
        exp3[0] = 3'd1; exp3[1] = 3'd2; exp3[2] = 3'd3; exp3[3] = 3'd4;
        exp5[0] = 3'd3; exp5[1] = 3'd4;
`else
        exp3[0] = 3'd2; exp3[1] = 3'd1; exp3[2] = 3'd3; exp3[3] = 3'd4;
        exp5[0] = 3'd4; exp5[1] = 3'd3;
`endif
        reset = 1'b1; flush = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_Vj = '0; bus.issue_Vk = '0;
        bus.issue_Qj = '0; bus.issue_Qk = '0; bus.issue_rj = 1'b0; bus.issue_rk = 1'b0;
        bus.issue_dest = '0; bus.alu_ready = 1'b0;
        cdb(1'b0, 3'd0, 16'h0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_count", 32'(busy_count), 0);
        chk("rst_valid", 32'(bus.alu_valid), 0);
        chk("rst_ready", 32'(bus.issue_ready), 1);
        chk("rst_a", 32'(bus.alu_a), 0);

        // 1: ready issue, two-edge latency
        bus.alu_ready = 1'b1;
        iss(16'd5, 16'd3, 3'd0, 1'b1, 3'd2);
        tick(); bus.issue_valid = 1'b0;
        chk("t1_busy", 32'(busy_out), 32'h1);
        chk("t1_nvalid", 32'(bus.alu_valid), 0);
        tick();
        chk("t1_valid", 32'(bus.alu_valid), 1);
        chk("t1_a", 32'(bus.alu_a), 5);
        chk("t1_b", 32'(bus.alu_b), 3);
        chk("t1_dest", 32'(bus.alu_dest), 2);
        chk("t1_op", 32'(bus.alu_op), 1);
        chk("t1_busy0", 32'(busy_out), 0);
        tick();
        chk("t1_drain", 32'(bus.alu_valid), 0);

        // 2: wakeup after a non-matching broadcast, then issue-cycle bypass
        iss(16'h0, 16'd7, 3'd4, 1'b0, 3'd3);
        tick(); bus.issue_valid = 1'b0;
        cdb(1'b1, 3'd6, 16'hffff);
        tick();
        chk("t2_nomatch_v", 32'(bus.alu_valid), 0);
        chk("t2_nomatch_b", 32'(busy_out), 32'h1);
        cdb(1'b1, 3'd4, 16'h1234);
        tick(); cdb(1'b0, 3'd0, 16'h0);
        chk("t2_wake_edge", 32'(bus.alu_valid), 0);
        tick();
        chk("t2_valid", 32'(bus.alu_valid), 1);
        chk("t2_a", 32'(bus.alu_a), 32'h1234);
        chk("t2_b", 32'(bus.alu_b), 7);
        chk("t2_dest", 32'(bus.alu_dest), 3);
        tick();
        iss(16'hdead, 16'd9, 3'd5, 1'b0, 3'd1);
        cdb(1'b1, 3'd5, 16'habcd);
        tick(); bus.issue_valid = 1'b0; cdb(1'b0, 3'd0, 16'h0);
        tick();
        chk("t2_byp_valid", 32'(bus.alu_valid), 1);
        chk("t2_byp_a", 32'(bus.alu_a), 32'habcd);
        chk("t2_byp_dest", 32'(bus.alu_dest), 1);
        tick();
        chk("t2_drain", 32'(bus.alu_valid), 0);

        // 3: fill with ALU stalled, extra issue ignored, then drain in selection order
        bus.alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iss(16'h10 + 16'(i), 16'h0, 3'd0, 1'b1, 3'(i));
            tick();
        end
        chk("t3_ready", 32'(bus.issue_ready), 0);
        chk("t3_count", 32'(busy_count), 4);
        chk("t3_busy", 32'(busy_out), 32'hf);
        chk("t3_hold_dest", 32'(bus.alu_dest), 0);
        chk("t3_hold_a", 32'(bus.alu_a), 32'h10);
        iss(16'h77, 16'h0, 3'd0, 1'b1, 3'd7);
        tick(); bus.issue_valid = 1'b0;
        chk("t3_full_count", 32'(busy_count), 4);
        chk("t3_full_hold", 32'(bus.alu_dest), 0);
        chk("t3_full_valid", 32'(bus.alu_valid), 1);
        bus.alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_drain%0d", i), 32'(bus.alu_dest), 32'(exp3[i]));
        end
        tick();
        chk("t3_empty_v", 32'(bus.alu_valid), 0);
        chk("t3_empty_b", 32'(busy_out), 0);

        // 4: flush beats a concurrent issue
        bus.alu_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            iss(16'h40 + 16'(i), 16'h0, 3'd0, 1'b1, 3'(i));
            tick();
        end
        chk("t4_pre_count", 32'(busy_count), 3);
        chk("t4_pre_valid", 32'(bus.alu_valid), 1);
        flush = 1'b1;
        iss(16'h55, 16'h0, 3'd0, 1'b1, 3'd5);
        tick(); flush = 1'b0; bus.issue_valid = 1'b0;
        chk("t4_busy", 32'(busy_out), 0);
        chk("t4_valid", 32'(bus.alu_valid), 0);
        chk("t4_dest", 32'(bus.alu_dest), 0);
        tick();
        chk("t4_count", 32'(busy_count), 0);
        chk("t4_valid2", 32'(bus.alu_valid), 0);

        // 5: reissue into a freed low slot; selection policy decides order
        iss(16'h77, 16'h0, 3'd0, 1'b1, 3'd7);
        tick(); bus.issue_valid = 1'b0;
        tick();
        chk("t5_blk", 32'(bus.alu_dest), 7);
        iss(16'h0, 16'h11, 3'd1, 1'b0, 3'd1); tick();
        iss(16'h0, 16'h22, 3'd2, 1'b0, 3'd2); tick();
        iss(16'h33, 16'h0, 3'd0, 1'b1, 3'd3); tick();
        bus.issue_valid = 1'b0;
        chk("t5_busy", 32'(busy_out), 32'h7);
        cdb(1'b1, 3'd1, 16'h1111);
        tick(); cdb(1'b0, 3'd0, 16'h0);
        chk("t5_hold", 32'(bus.alu_dest), 7);
        bus.alu_ready = 1'b1;
        tick(); bus.alu_ready = 1'b0;
        chk("t5_e0_dest", 32'(bus.alu_dest), 1);
        chk("t5_e0_a", 32'(bus.alu_a), 32'h1111);
        chk("t5_e0_busy", 32'(busy_out), 32'h6);
        iss(16'h44, 16'h0, 3'd0, 1'b1, 3'd4);
        tick(); bus.issue_valid = 1'b0;
        chk("t5_reissue", 32'(busy_out), 32'h7);
        bus.alu_ready = 1'b1;
        tick();
        chk("t5_first", 32'(bus.alu_dest), 32'(exp5[0]));
        tick();
        chk("t5_second", 32'(bus.alu_dest), 32'(exp5[1]));
        tick();
        chk("t5_idle", 32'(bus.alu_valid), 0);
        chk("t5_wait_busy", 32'(busy_out), 32'h2);
        cdb(1'b1, 3'd2, 16'h2222);
        tick(); cdb(1'b0, 3'd0, 16'h0);
        tick();
        chk("t5_last_dest", 32'(bus.alu_dest), 2);
        chk("t5_last_a", 32'(bus.alu_a), 32'h2222);
        tick();
        chk("t5_empty", 32'(busy_out), 0);

        // 6: back-to-back issues, one dispatch per cycle in order
        for (int i = 0; i < 6; i++) begin
            iss(16'h60 + 16'(i), 16'h0, 3'd0, 1'b1, 3'(i));
            tick();
            if (i > 0) begin
                chk($sformatf("t6_v%0d", i), 32'(bus.alu_valid), 1);
                chk($sformatf("t6_d%0d", i), 32'(bus.alu_dest), 32'(i - 1));
                chk($sformatf("t6_a%0d", i), 32'(bus.alu_a), 32'h60 + 32'(i - 1));
            end
        end
        bus.issue_valid = 1'b0;
        tick();
        chk("t6_last", 32'(bus.alu_dest), 5);
        tick();
        chk("t6_idle", 32'(bus.alu_valid), 0);
        chk("t6_busy", 32'(busy_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
